// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side command/response bundle plus the APB master command and bus-monitor signals.
// The master modport is the arbiter's view; the slave modport is the surrounding subsystem.
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0]     req_strb;
    logic [NUM_REQ*PROT_W-1:0]     req_prot;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic                          transfer;
    logic                          WRITE_READ;
    logic [ADDR_WIDTH-1:0]         apb_addr;
    logic [DATA_WIDTH-1:0]         apb_wdata;
    logic [STRB_W-1:0]             PSTRB;
    logic [PROT_W-1:0]             PPROT;

    logic                          PSELx;
    logic                          PENABLE;
    logic                          PREADY;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  PSELx, PENABLE, PREADY, PRDATA, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output transfer, WRITE_READ, apb_addr, apb_wdata, PSTRB, PPROT
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output PSELx, PENABLE, PREADY, PRDATA, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  transfer, WRITE_READ, apb_addr, apb_wdata, PSTRB, PPROT
    );

endinterface

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last_grant_i+1.
module apb_rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        logic            found;
        logic [IdxW-1:0] cand;
        found     = 1'b0;
        cand      = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        // k = NUM_REQ wraps back to last_grant_i itself, so it has lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_grant_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters, one command at a time.
// Define APB_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES cycles.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic               PCLK,
    input logic               PRESETn,
    apb_req_arbiter_if.master bus_io
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("apb_req_arbiter: parameter out of range");
    end

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       win_q, win_d;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [STRB_W-1:0]     cmd_strb_q, cmd_strb_d;
    logic [PROT_W-1:0]     cmd_prot_q, cmd_prot_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]     strb_arr  [NUM_REQ];
    logic [PROT_W-1:0]     prot_arr  [NUM_REQ];

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_any;
    logic               done;
    logic               abort;
    logic               timeout;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus_io.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = bus_io.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign strb_arr[g]  = bus_io.req_strb[g*STRB_W +: STRB_W];
        assign prot_arr[g]  = bus_io.req_prot[g*PROT_W +: PROT_W];
    end

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i        (bus_io.req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (pick_gnt),
        .gnt_idx_o    (pick_idx),
        .any_o        (pick_any)
    );

    assign done  = bus_io.PSELx & bus_io.PENABLE & bus_io.PREADY;
    // A dropped select or an error while waiting means the master gave up on our transfer.
    assign abort = (state_q == ARB_WAIT) & (~bus_io.PSELx | bus_io.PSLVERR);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    assign to_cnt_d = (state_q == ARB_WAIT) ? to_cnt_q + 1'b1 : '0;
    assign timeout  = (state_q == ARB_WAIT) & (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ARB_IDLE;
            win_q        <= '0;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_strb_q   <= '0;
            cmd_prot_q   <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_strb_q   <= cmd_strb_d;
            cmd_prot_q   <= cmd_prot_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_strb_d   = cmd_strb_q;
        cmd_prot_d   = cmd_prot_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d     = ARB_ISSUE;
                    win_d       = pick_idx;
                    cmd_write_d = bus_io.req_write[pick_idx];
                    cmd_addr_d  = addr_arr[pick_idx];
                    cmd_wdata_d = wdata_arr[pick_idx];
                    cmd_strb_d  = strb_arr[pick_idx];
                    cmd_prot_d  = prot_arr[pick_idx];
                end
            end
            ARB_ISSUE: begin
                if (bus_io.PSELx) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (done) begin
                    state_d = ARB_RESP;
                    rdata_d = cmd_write_q ? '0 : bus_io.PRDATA;
                    err_d   = bus_io.PSLVERR;
                end else if (abort || timeout) begin
                    state_d = ARB_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ARB_RESP: begin
                state_d      = ARB_IDLE;
                last_grant_d = win_q;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus_io.req_ready = (state_q == ARB_IDLE) ? pick_gnt : '0;
        bus_io.rsp_valid = '0;
        bus_io.rsp_rdata = '0;
        bus_io.rsp_err   = 1'b0;
        if (state_q == ARB_RESP) begin
            bus_io.rsp_valid[win_q] = 1'b1;
            bus_io.rsp_rdata        = rdata_q;
            bus_io.rsp_err          = err_q;
        end
        // Combinational drop lets the master return to IDLE straight after ACCESS.
        bus_io.transfer   = ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT)) &
                            ~done & ~abort & ~timeout;
        bus_io.WRITE_READ = cmd_write_q;
        bus_io.apb_addr   = cmd_addr_q;
        bus_io.apb_wdata  = cmd_wdata_q;
        bus_io.PSTRB      = cmd_strb_q;
        bus_io.PPROT      = cmd_prot_q;
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter with a behavioural APB master/slave on the bus side.
// Define APB_ARB_TIMEOUT_EN to also exercise the WAIT-state timeout.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int unsigned NumReq        = 4;
    localparam int unsigned TimeoutCycles = 8;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if #(
        .NUM_REQ    (NumReq),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) bus ();

    apb_req_arbiter #(
        .NUM_REQ        (NumReq),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus_io  (bus)
    );

    // Bus model: master IDLE/SETUP/ACCESS driven by transfer, slave inserts cfg_waits wait states.
    int unsigned cfg_waits = 0;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_err   = 1'b0;
    logic [1:0]  m_st;
    int unsigned m_wcnt;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_st   <= 2'd0;
            m_wcnt <= 0;
        end else begin
            case (m_st)
                2'd0: if (bus.transfer) m_st <= 2'd1;
                2'd1: begin
                    m_st   <= 2'd2;
                    m_wcnt <= cfg_waits;
                end
                default: begin
                    if (m_wcnt != 0) m_wcnt <= m_wcnt - 1;
                    else m_st <= bus.transfer ? 2'd1 : 2'd0;
                end
            endcase
        end
    end

    assign bus.PSELx   = (m_st != 2'd0);
    assign bus.PENABLE = (m_st == 2'd2);
    assign bus.PREADY  = (m_st == 2'd2) && (m_wcnt == 0);
    assign bus.PRDATA  = cfg_rdata;
    assign bus.PSLVERR = bus.PREADY & cfg_err;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic drive_req(input int idx, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [2:0] prot);
        bus.req_write[idx]          = wr;
        bus.req_addr[idx*32 +: 32]  = addr;
        bus.req_wdata[idx*32 +: 32] = wdata;
        bus.req_strb[idx*4 +: 4]    = strb;
        bus.req_prot[idx*3 +: 3]    = prot;
        bus.req_valid[idx]          = 1'b1;
    endtask

    // One command from one requester, checking accept, transfer profile, bus command and latency.
    task automatic xfer(input int idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] rdata, input int waits, input logic err);
        exp_t       e;
        logic [3:0] exp_v;
        logic       got;
        @(negedge PCLK);
        cfg_waits = waits;
        cfg_rdata = rdata;
        cfg_err   = err;
        drive_req(idx, wr, addr, wdata, strb, prot);
        #1;
        exp_v = 4'b0001 << idx;
        n_checks++;
        if (bus.req_ready !== exp_v)
            $display("FAIL accept_req%0d: got req_ready=%b, required %b", idx, bus.req_ready, exp_v);
        else n_pass++;
        e.idx   = idx;
        e.rdata = wr ? 32'h0 : rdata;
        e.err   = err;
        sb_q.push_back(e);
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge PCLK);
            if (c == 1) bus.req_valid[idx] = 1'b0;
            #1;
            if (bus.rsp_valid != 0) begin
                got = 1'b1;
                n_checks++;
                if (c != 4 + waits)
                    $display("FAIL rsp_latency: got cycle %0d, required cycle %0d", c, 4 + waits);
                else n_pass++;
                e = sb_q.pop_front();
                exp_v = 4'b0001 << e.idx;
                n_checks++;
                if (bus.rsp_valid !== exp_v || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
                    $display("FAIL rsp: got valid=%b rdata=%h err=%b, required valid=%b rdata=%h err=%b",
                             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, exp_v, e.rdata, e.err);
                else n_pass++;
            end else begin
                n_checks++;
                if (bus.transfer !== (c <= 2 + waits))
                    $display("FAIL transfer_c%0d: got %b, required %b", c, bus.transfer,
                             (c <= 2 + waits));
                else n_pass++;
                if (c == 2) begin
                    n_checks++;
                    if ({bus.WRITE_READ, bus.apb_addr, bus.apb_wdata, bus.PSTRB, bus.PPROT} !==
                        {wr, addr, wdata, strb, prot})
                        $display("FAIL bus_cmd: got wr=%b addr=%h wdata=%h strb=%h prot=%h, required wr=%b addr=%h wdata=%h strb=%h prot=%h",
                                 bus.WRITE_READ, bus.apb_addr, bus.apb_wdata, bus.PSTRB, bus.PPROT,
                                 wr, addr, wdata, strb, prot);
                    else n_pass++;
                end
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL rsp_timeout: got no rsp_valid in 40 cycles, required one");
        end
    endtask

    task automatic test_reset;
        PRESETn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        #1;
        n_checks++;
        if ({bus.transfer, bus.WRITE_READ, bus.apb_addr, bus.apb_wdata, bus.PSTRB, bus.PPROT,
             bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.rsp_valid} !== '0)
            $display("FAIL reset_outputs: got transfer=%b ready=%b rsp_valid=%b addr=%h, required all 0",
                     bus.transfer, bus.req_ready, bus.rsp_valid, bus.apb_addr);
        else n_pass++;
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_single_write;
        xfer(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'hCAFEF00D, 0, 1'b0);
    endtask

    task automatic test_round_robin;
        exp_t       e;
        logic [3:0] exp_v;
        logic [3:0] drop;
        logic [3:0] raise;
        int         remaining[4];
        int         exp_order[$];
        int         grants;
        int         gi;
        int         eg;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        cfg_waits = 0;
        cfg_err   = 1'b0;
        cfg_rdata = 32'hA5A5A5A5;
        @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(i, 1'b1, 32'h100 + 4 * i, 32'h1000_0000 + i, 4'hF, 3'b001);
            remaining[i] = 1;
        end
        drop   = '0;
        raise  = '0;
        grants = 0;
        for (int c = 0; c < 300 && (grants < 8 || sb_q.size() != 0); c++) begin
            if (c != 0) begin
                @(negedge PCLK);
                bus.req_valid = (bus.req_valid & ~drop) | raise;
                drop  = '0;
                raise = '0;
            end
            #1;
            if (bus.rsp_valid != 0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL rr_rsp_unexpected: got rsp_valid=%b, required none", bus.rsp_valid);
                end else begin
                    e = sb_q.pop_front();
                    exp_v = 4'b0001 << e.idx;
                    if (bus.rsp_valid !== exp_v || bus.rsp_rdata !== e.rdata ||
                        bus.rsp_err !== e.err)
                        $display("FAIL rr_rsp: got valid=%b rdata=%h err=%b, required valid=%b rdata=%h err=%b",
                                 bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, exp_v, e.rdata, e.err);
                    else n_pass++;
                end
                for (int i = 0; i < 4; i++) begin
                    if (bus.rsp_valid[i] && remaining[i] > 0) begin
                        raise[i] = 1'b1;
                        remaining[i]--;
                    end
                end
            end
            if (bus.req_ready != 0) begin
                gi = -1;
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gi = i;
                eg = (exp_order.size() != 0) ? exp_order.pop_front() : -1;
                n_checks++;
                if (gi != eg) $display("FAIL rr_grant%0d: got requester %0d, required %0d",
                                       grants, gi, eg);
                else n_pass++;
                e.idx   = gi;
                e.rdata = 32'h0;
                e.err   = 1'b0;
                sb_q.push_back(e);
                drop = bus.req_ready;
                grants++;
            end
        end
        n_checks++;
        if (grants != 8 || sb_q.size() != 0)
            $display("FAIL rr_complete: got %0d grants with %0d responses pending, required 8 and 0",
                     grants, sb_q.size());
        else n_pass++;
    endtask

    task automatic test_wait_read;
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b010, 32'h12345678, 3, 1'b0);
    endtask

    task automatic test_slverr;
        xfer(1, 1'b1, 32'h30, 32'h55AA55AA, 4'h3, 3'b000, 32'h11111111, 0, 1'b1);
        xfer(2, 1'b0, 32'h34, 32'h0, 4'hF, 3'b000, 32'h0BADF00D, 1, 1'b0);
    endtask

    task automatic test_reset_mid_wait;
        exp_t       e;
        logic       got;
        cfg_waits = 10;
        cfg_err   = 1'b0;
        @(negedge PCLK);
        drive_req(1, 1'b1, 32'h44, 32'h77, 4'h3, 3'b101);
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0010)
            $display("FAIL rst_accept: got req_ready=%b, required 0010", bus.req_ready);
        else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            @(negedge PCLK);
            if (c == 1) bus.req_valid[1] = 1'b0;
        end
        #1;
        n_checks++;
        if (bus.transfer !== 1'b1)
            $display("FAIL rst_pre_wait: got transfer=%b, required 1", bus.transfer);
        else n_pass++;
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({bus.transfer, bus.WRITE_READ, bus.apb_addr, bus.apb_wdata, bus.PSTRB, bus.PPROT,
             bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.rsp_valid} !== '0)
            $display("FAIL rst_async: got transfer=%b wr=%b addr=%h wdata=%h, required all 0",
                     bus.transfer, bus.WRITE_READ, bus.apb_addr, bus.apb_wdata);
        else n_pass++;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn   = 1'b1;
        cfg_waits = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge PCLK);
            #1;
            n_checks++;
            if (bus.rsp_valid !== '0 || bus.transfer !== 1'b0)
                $display("FAIL rst_silent: got rsp_valid=%b transfer=%b, required 0 and 0",
                         bus.rsp_valid, bus.transfer);
            else n_pass++;
        end
        @(negedge PCLK);
        for (int i = 0; i < 4; i++) drive_req(i, 1'b1, 32'h200 + i, 32'h0, 4'hF, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001)
            $display("FAIL rst_first_grant: got req_ready=%b, required 0001", bus.req_ready);
        else n_pass++;
        e.idx   = 0;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        sb_q.push_back(e);
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge PCLK);
            if (c == 1) bus.req_valid = '0;
            #1;
            if (bus.rsp_valid != 0) begin
                got = 1'b1;
                e = sb_q.pop_front();
                n_checks++;
                if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
                    $display("FAIL rst_rsp: got valid=%b rdata=%h err=%b, required valid=0001 rdata=%h err=%b",
                             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                else n_pass++;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL rst_rsp_timeout: got no rsp_valid in 20 cycles, required one");
        end
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        exp_t e;
        logic got;
        cfg_waits = 1000;
        cfg_err   = 1'b0;
        cfg_rdata = 32'h5555AAAA;
        @(negedge PCLK);
        drive_req(3, 1'b0, 32'h80, 32'h0, 4'hF, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b1000)
            $display("FAIL to_accept: got req_ready=%b, required 1000", bus.req_ready);
        else n_pass++;
        e.idx   = 3;
        e.rdata = 32'h0;
        e.err   = 1'b1;
        sb_q.push_back(e);
        got = 1'b0;
        for (int c = 1; c <= 3 + TimeoutCycles + 10 && !got; c++) begin
            @(negedge PCLK);
            if (c == 1) bus.req_valid[3] = 1'b0;
            #1;
            if (bus.rsp_valid != 0) begin
                got = 1'b1;
                n_checks++;
                if (c != 3 + TimeoutCycles)
                    $display("FAIL to_latency: got cycle %0d, required cycle %0d", c,
                             3 + TimeoutCycles);
                else n_pass++;
                e = sb_q.pop_front();
                n_checks++;
                if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err)
                    $display("FAIL to_rsp: got valid=%b rdata=%h err=%b, required valid=1000 rdata=%h err=%b",
                             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                else n_pass++;
            end else begin
                n_checks++;
                if (bus.transfer !== (c <= 1 + TimeoutCycles))
                    $display("FAIL to_transfer_c%0d: got %b, required %b", c, bus.transfer,
                             (c <= 1 + TimeoutCycles));
                else n_pass++;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL to_rsp_timeout: got no rsp_valid, required one");
        end
        // The bus model is still stuck in ACCESS; clear it before anything else runs.
        @(negedge PCLK);
        PRESETn   = 1'b0;
        cfg_waits = 0;
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required earlier finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wait_read();
        test_slverr();
        test_reset_mid_wait();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
